mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU/execute stage.
- Latches the execute result and uses the ALU adder output as the effective address for loads and stores.
- Runs byte/half/word accesses on the data bus with a req/ack handshake and formats load data.
- Holds the architectural EQ/LT flag register that feeds back to condition evaluation. It then presents one writeback record per instruction.

Parameters:
- ADDR_W, 32, data-bus address width (low 2 bits always driven 0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_rd  in  5  destination register (0 = no write)
- ex_res  in  32  ALU result (res)
- ex_addr  in  32  effective address (ALU add_out)
- ex_sdata  in  32  store data, unaligned in low bits
- ex_mem_op  in  2  mem_op_e: NONE/LOAD/STORE
- ex_size  in  2  size_e: BYTE/HALF/WORD
- ex_sext  in  1  sign-extend load
- ex_cmp_res  in  2  ALU compare result [EQ], [LT]
- ex_set_flags  in  1  update flag register
- flags  out  2  flag register [EQ], [LT]
- dbus_req  out  1  bus request
- dbus_we  out  1  write
- dbus_addr  out  ADDR_W  word-aligned address
- dbus_wdata  out  32  lane-replicated store data
- dbus_wstrb  out  4  byte strobes
- dbus_ack  in  1  bus completes (rdata valid the same cycle)
- dbus_rdata  in  32  read data
- wb_valid  out  1  writeback record valid (1-cycle pulse)
- wb_we  out  1  write register file
- wb_rd  out  5  destination
- wb_data  out  32  write data
- misalign  out  1  1-cycle pulse, with wb_valid, on a misaligned access

Behaviour:
- Reset (async, rst_n=0): state IDLE; flags=0; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_wstrb=0; wb_valid=0, wb_we=0, wb_rd=0, wb_data=0; misalign=0. All outputs registered except ex_ready.
- FSM states: IDLE, BUS.
- ex_ready = (state==IDLE). The stage accepts when ex_valid & ex_ready.
- Flags: on accept with ex_set_flags, flags<=ex_cmp_res, visible the next cycle. This is independent of mem_op, and the update is kept even if the access misaligns.
- Accept, NONE: next cycle wb_valid=1, wb_data=ex_res, wb_rd=ex_rd, wb_we=(ex_rd!=0). Latency 1. Back-to-back accepts every cycle.
- Misaligned access: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
  - No bus request.
  - Next cycle wb_valid=1, wb_we=0, misalign=1.
  - State stays IDLE.
- Accept, aligned LOAD/STORE:
  - Next cycle state=BUS, dbus_req=1, dbus_addr={addr[31:2],2'b00}, dbus_we=(STORE).
  - Strobes: BYTE 0001<<addr[1:0]; HALF 0011<<addr[1:0]; WORD 1111.
  - wdata: BYTE {4{sdata[7:0]}}; HALF {2{sdata[15:0]}}; WORD sdata.
  - Latch rd, size, sext and addr[1:0].
- BUS state:
  - dbus_req, addr, we, wdata and wstrb are held stable until dbus_ack.
  - On the ack cycle, dbus_req drops at the next edge and state returns to IDLE.
  - Next cycle wb_valid=1. LOAD: wb_data = selected lane, zero- or sign-extended to 32; wb_we=(rd!=0). STORE: wb_we=0.
  - ack in the first BUS cycle is legal.
  - ack while not in BUS is ignored.
- Minimum access latency: accept -> req 1 cycle; ack -> wb_valid 1 cycle.
- wb_valid is a single-cycle pulse. wb_data/wb_rd hold their last values while wb_valid=0. misalign=0 except as stated.
- Reset mid-access: drops dbus_req immediately (async). The transaction is abandoned and no writeback occurs.
- Arithmetic: no arithmetic beyond lane select and extension; addresses are not modified.

Decomposition:
- Package br32_pkg holds:
  - mem_op_e (NONE=0, LOAD=1, STORE=2)
  - size_e (BYTE=0, HALF=1, WORD=2)
  - flag indices EQ=0, LT=1, shared with the ALU compare encoding
  - stage_e (IDLE, BUS)
- One combinational sub-module, mem_align. It produces the misaligned flag, strobes and replicated wdata for stores, and the extracted, extended load data from rdata, offset, size and sext.

Test Plan:
- NONE ex_res=0xDEADBEEF, rd=5, set_flags=1, cmp_res=2'b10 -> next cycle wb_valid, wb_we=1, wb_data=0xDEADBEEF, flags=2'b10. Three back-to-back NONEs give three consecutive wb_valid pulses.
- LOAD BYTE sext=1 at addr 0x1003, rdata=0x80FF_0000, ack after 3 cycles -> dbus_addr=0x1000, req held 3 cycles, wb_data=0xFFFFFF80. Repeat with sext=0 -> 0x00000080.
- STORE HALF sdata=0x1234ABCD at addr 0x2002 -> wstrb=1100, wdata=0xABCDABCD, we=1. After ack, wb_valid=1, wb_we=0, and ex_ready is low during BUS.
- WORD LOAD at addr 0x3001 with set_flags=1 -> no dbus_req, wb_valid=1, misalign=1, wb_we=0, flags updated.
- LOAD to rd=0 with same-cycle ack -> wb_we=0. Then assert rst_n=0 while in BUS on a second load -> dbus_req=0 immediately, flags=0, no wb_valid after release.

Source files
------------

// File: rtl/br32_pkg.sv
// Shared encodings for the br32 pipeline: memory op, access size, flag bit
// positions (matching the ALU compare result) and the memory-stage states.
package br32_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    localparam int EQ = 0;
    localparam int LT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } stage_e;

endpackage

// File: rtl/mem_align.sv
// Pure lane logic: alignment check, store strobes/replication and load
// lane extraction with optional sign extension.
module mem_align
    import br32_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sext,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        misaligned = 1'b0;
        wstrb      = 4'b1111;
        wdata      = sdata;
        ldata      = rdata;
        case (size)
            BYTE: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sext & byte_lane[7]}}, byte_lane};
            end
            HALF: begin
                misaligned = offset[0];
                wstrb      = 4'b0011 << offset;
                wdata      = {2{sdata[15:0]}};
                ldata      = {{16{sext & half_lane[15]}}, half_lane};
            end
            // WORD and the unused encoding both behave as a full word
            default: begin
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: accepts one execute result at a time, runs at most one data
// bus access, owns the EQ/LT flag register and emits one writeback record.
module mem_stage
    import br32_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd,
    input  logic [31:0]       ex_res,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_sdata,
    input  logic [1:0]        ex_mem_op,
    input  logic [1:0]        ex_size,
    input  logic              ex_sext,
    input  logic [1:0]        ex_cmp_res,
    input  logic              ex_set_flags,
    output logic [1:0]        flags,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_wstrb,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign
);

    // Handshake: an instruction transfers on any rising edge where
    // ex_valid && ex_ready; the bus transfer completes on the edge where
    // dbus_req && dbus_ack, with request fields held stable until then.
    stage_e      state, state_d;
    logic        accept, is_mem, is_store;
    logic [4:0]  lat_rd;
    size_e       lat_size;
    logic        lat_sext;
    logic [1:0]  lat_off;
    size_e       al_size;
    logic [1:0]  al_off;
    logic        al_mis;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_ldata;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign is_store = (mem_op_e'(ex_mem_op) == STORE);
    assign is_mem   = (mem_op_e'(ex_mem_op) == LOAD) || is_store;

    // Store formatting only happens while idle and load extraction only in
    // BUS, so one aligner serves both by switching its inputs on state.
    assign al_size = (state == BUS) ? lat_size : size_e'(ex_size);
    assign al_off  = (state == BUS) ? lat_off  : ex_addr[1:0];

    mem_align u_align (
        .size       (al_size),
        .offset     (al_off),
        .sext       (lat_sext),
        .sdata      (ex_sdata),
        .rdata      (dbus_rdata),
        .misaligned (al_mis),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .ldata      (al_ldata)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept && is_mem && !al_mis) state_d = BUS;
            BUS:     if (dbus_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= 2'b00;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_wstrb <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            misalign   <= 1'b0;
            lat_rd     <= '0;
            lat_size   <= BYTE;
            lat_sext   <= 1'b0;
            lat_off    <= '0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            if (state == IDLE && accept) begin
                if (ex_set_flags) flags <= ex_cmp_res;
                if (is_mem && al_mis) begin
                    wb_valid <= 1'b1;
                    wb_we    <= 1'b0;
                    wb_rd    <= ex_rd;
                    misalign <= 1'b1;
                end else if (is_mem) begin
                    dbus_req   <= 1'b1;
                    dbus_we    <= is_store;
                    dbus_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
                    dbus_wdata <= al_wdata;
                    dbus_wstrb <= al_wstrb;
                    lat_rd     <= ex_rd;
                    lat_size   <= size_e'(ex_size);
                    lat_sext   <= ex_sext;
                    lat_off    <= ex_addr[1:0];
                end else begin
                    wb_valid <= 1'b1;
                    wb_we    <= (ex_rd != 5'd0);
                    wb_rd    <= ex_rd;
                    wb_data  <= ex_res;
                end
            end else if (state == BUS && dbus_ack) begin
                dbus_req <= 1'b0;
                wb_valid <= 1'b1;
                wb_rd    <= lat_rd;
                wb_we    <= !dbus_we && (lat_rd != 5'd0);
                if (!dbus_we) wb_data <= al_ldata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drivers push expected writeback records,
// a negedge monitor pops and compares them as wb_valid pulses appear.
module tb_mem_stage;
    import br32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_res = '0, ex_addr = '0, ex_sdata = '0;
    logic [1:0]  ex_mem_op = '0, ex_size = '0, ex_cmp_res = '0;
    logic        ex_sext = 1'b0, ex_set_flags = 1'b0;
    logic [1:0]  flags;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        wb_valid, wb_we, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;
    // {check_rd_data, misalign, we, rd[4:0], data[31:0]}
    logic [39:0] exp_q[$];

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
        .ex_res(ex_res), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_mem_op(ex_mem_op), .ex_size(ex_size), .ex_sext(ex_sext),
        .ex_cmp_res(ex_cmp_res), .ex_set_flags(ex_set_flags), .flags(flags),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign(misalign)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mk_exp(input logic chk, input logic mis, input logic we,
                                           input logic [4:0] rd, input logic [31:0] data);
        return {chk, mis, we, rd, data};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [39:0] e;
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: actual rd=%0d data=%h required no record", wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_misalign", {31'd0, misalign}, {31'd0, e[38]});
                check("wb_we", {31'd0, wb_we}, {31'd0, e[37]});
                if (e[39]) begin
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
                    check("wb_data", wb_data, e[31:0]);
                end
            end
        end else if (rst_n && misalign) begin
            check("misalign_no_wb", {31'd0, misalign}, 32'd0);
        end
    end

    // drivers
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sext,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic setf, input logic [1:0] cmp);
        int n = 0;
        while (!ex_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ex_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: actual ex_ready=0 required 1");
        end
        ex_valid = 1'b1; ex_mem_op = op; ex_size = size; ex_sext = sext; ex_rd = rd;
        ex_res = res; ex_addr = addr; ex_sdata = sdata; ex_set_flags = setf; ex_cmp_res = cmp;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_set_flags = 1'b0;
    endtask

    task automatic bus_resp(input int cycles, input logic [31:0] rdata, input logic [31:0] addr,
                            input logic we, input logic [3:0] strb, input logic [31:0] wdata);
        for (int i = 0; i < cycles; i++) begin
            check("dbus_req_held", {31'd0, dbus_req}, 32'd1);
            check("ex_ready_in_bus", {31'd0, ex_ready}, 32'd0);
            check("dbus_addr", dbus_addr, addr);
            check("dbus_we", {31'd0, dbus_we}, {31'd0, we});
            check("dbus_wstrb", {28'd0, dbus_wstrb}, {28'd0, strb});
            if (we) check("dbus_wdata", dbus_wdata, wdata);
            if (i == cycles - 1) begin
                dbus_ack = 1'b1;
                dbus_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0;
        check("dbus_req_drop", {31'd0, dbus_req}, 32'd0);
        check("ex_ready_after_ack", {31'd0, ex_ready}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_flags", {30'd0, flags}, 32'd0);
        check("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_dbus_wstrb", {28'd0, dbus_wstrb}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // NONE with flag update
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF));
        issue(NONE, WORD, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 2'b10);
        check("flags_after_none", {30'd0, flags}, 32'd2);
        check("flag_lt_bit", {31'd0, flags[LT]}, 32'd1);

        // three back-to-back NONEs, last one to rd=0
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd1, 32'h00000011));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd2, 32'h00000022));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'h00000033));
        issue(NONE, WORD, 1'b0, 5'd1, 32'h11, 32'h0, 32'h0, 1'b0, 2'b00);
        issue(NONE, WORD, 1'b0, 5'd2, 32'h22, 32'h0, 32'h0, 1'b0, 2'b00);
        issue(NONE, WORD, 1'b0, 5'd0, 32'h33, 32'h0, 32'h0, 1'b0, 2'b00);
        check("flags_kept", {30'd0, flags}, 32'd2);

        // byte loads at offset 3, signed then unsigned
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd7, 32'hFFFFFF80));
        issue(LOAD, BYTE, 1'b1, 5'd7, 32'h0, 32'h00001003, 32'h0, 1'b0, 2'b00);
        bus_resp(3, 32'h80FF0000, 32'h00001000, 1'b0, 4'b1000, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd8, 32'h00000080));
        issue(LOAD, BYTE, 1'b0, 5'd8, 32'h0, 32'h00001003, 32'h0, 1'b0, 2'b00);
        bus_resp(3, 32'h80FF0000, 32'h00001000, 1'b0, 4'b1000, 32'h0);

        // half store at offset 2
        exp_q.push_back(mk_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        issue(STORE, HALF, 1'b0, 5'd9, 32'h0, 32'h00002002, 32'h1234ABCD, 1'b0, 2'b00);
        bus_resp(2, 32'h0, 32'h00002000, 1'b1, 4'b1100, 32'hABCDABCD);

        // signed half load from the upper lane, word store
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd10, 32'hFFFF8001));
        issue(LOAD, HALF, 1'b1, 5'd10, 32'h0, 32'h00005002, 32'h0, 1'b0, 2'b00);
        bus_resp(2, 32'h80017FFF, 32'h00005000, 1'b0, 4'b1100, 32'h0);
        exp_q.push_back(mk_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        issue(STORE, WORD, 1'b0, 5'd11, 32'h0, 32'h00006000, 32'hCAFEF00D, 1'b0, 2'b00);
        bus_resp(1, 32'h0, 32'h00006000, 1'b1, 4'b1111, 32'hCAFEF00D);

        // misaligned word load still updates flags
        exp_q.push_back(mk_exp(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
        issue(LOAD, WORD, 1'b0, 5'd3, 32'h0, 32'h00003001, 32'h0, 1'b1, 2'b01);
        check("mis_no_req", {31'd0, dbus_req}, 32'd0);
        check("mis_ready", {31'd0, ex_ready}, 32'd1);
        check("mis_flags", {30'd0, flags}, 32'd1);
        check("flag_eq_bit", {31'd0, flags[EQ]}, 32'd1);
        @(posedge clk); #1;
        check("mis_no_req_later", {31'd0, dbus_req}, 32'd0);

        // load to rd=0 with ack in the first BUS cycle
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd0, 32'h11223344));
        issue(LOAD, WORD, 1'b0, 5'd0, 32'h0, 32'h00004000, 32'h0, 1'b0, 2'b00);
        bus_resp(1, 32'h11223344, 32'h00004000, 1'b0, 4'b1111, 32'h0);

        // stray ack while idle is ignored
        @(posedge clk); #1;
        dbus_ack = 1'b1;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        check("idle_ack_no_req", {31'd0, dbus_req}, 32'd0);

        // reset in the middle of an access
        issue(LOAD, BYTE, 1'b0, 5'd4, 32'h0, 32'h00007001, 32'h0, 1'b0, 2'b00);
        check("mid_req_up", {31'd0, dbus_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, dbus_req}, 32'd0);
        check("mid_rst_flags", {30'd0, flags}, 32'd0);
        check("mid_rst_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_req", {31'd0, dbus_req}, 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
